hacd_reg_arbiter: RTL

- Shares the single 32-bit HACD register request interface (valid/write/wstrb/addr/wdata to ready/rdata) between two requesters.
- Requester 0 is the NoC AXI-lite bridge front-end. Requester 1 is an internal hardware requester, such as the compression engine's descriptor/stat poller.
- Arbitration is round-robin, with a lock so that the two 32-bit beats of a 64-bit access are never interleaved with the other requester.
- A lock watchdog prevents a stuck requester from starving the other.

---
 rtl/hacd_reg_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/hacd_reg_arbiter.sv
// hacd_reg_arbiter: shares the 32-bit HACD register port between r0 (NoC AXI-lite bridge) and r1 (internal poller).
// Latency: zero-cycle combinational path from the granted requester to s_*; grant state advances on clk_i.
// Backpressure: s_ready_i goes straight to the granted requester; the other sees ready=0. Optional stats: HACD_REG_ARB_STATS_EN.
module hacd_reg_arbiter #(
   parameter int LOCK_TIMEOUT = 16,
   parameter int CNT_W        = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        r0_valid_i,
   input  logic        r0_write_i,
   input  logic [3:0]  r0_wstrb_i,
   input  logic [31:0] r0_addr_i,
   input  logic [31:0] r0_wdata_i,
   input  logic        r0_lock_i,
   output logic        r0_ready_o,
   output logic [31:0] r0_rdata_o,
   input  logic        r1_valid_i,
   input  logic        r1_write_i,
   input  logic [3:0]  r1_wstrb_i,
   input  logic [31:0] r1_addr_i,
   input  logic [31:0] r1_wdata_i,
   input  logic        r1_lock_i,
   output logic        r1_ready_o,
   output logic [31:0] r1_rdata_o,
   output logic        s_valid_o,
   output logic        s_write_o,
   output logic [3:0]  s_wstrb_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_ready_i,
   input  logic [31:0] s_rdata_i,
`ifdef HACD_REG_ARB_STATS_EN
   output logic [CNT_W-1:0] grant_cnt0_o,
   output logic [CNT_W-1:0] grant_cnt1_o,
   output logic [7:0]       timeout_cnt_o,
`endif
   output logic        lock_err_o,
   output logic [1:0]  owner_o
);

   // Reject parameter values the 8-bit watchdog counter or the stats counters cannot represent.
   if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
      $error("hacd_reg_arbiter: LOCK_TIMEOUT must be 1..255 and CNT_W >= 1");
   end

   localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state;
   logic        own_r1;     // holder in BUSY/LOCKED: 0 = r0, 1 = r1
   logic        rr_last;    // requester that completed last: 0 = r0, 1 = r1
   logic [7:0]  lock_cnt;   // idle cycles of the lock holder while LOCKED

   logic gnt0, gnt1, sel0, sel1, owner_valid, timeout, done, cur_lock;

   // Grant decision for the current cycle; nothing is granted while reset is asserted.
   always_comb begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      timeout     = 1'b0;
      owner_valid = own_r1 ? r1_valid_i : r0_valid_i;
      if (!rst_i) begin
         case (state)
            ST_IDLE: begin
               if (r0_valid_i && r1_valid_i) begin
                  // contention: the requester that did not go last wins
                  gnt0 = rr_last;
                  gnt1 = !rr_last;
               end else begin
                  gnt0 = r0_valid_i;
                  gnt1 = r1_valid_i;
               end
            end
            ST_BUSY: begin
               gnt0 = !own_r1;
               gnt1 = own_r1;
            end
            ST_LOCKED: begin
               if (!owner_valid && lock_cnt == LOCK_LIMIT) begin
                  // holder went quiet too long: release this cycle, grant nobody
                  timeout = 1'b1;
               end else begin
                  gnt0 = !own_r1;
                  gnt1 = own_r1;
               end
            end
            default: begin
               gnt0 = 1'b0;
               gnt1 = 1'b0;
            end
         endcase
      end
   end

   // A grant only drives the register port while the granted requester is actually presenting a beat.
   assign sel0 = gnt0 & r0_valid_i;
   assign sel1 = gnt1 & r1_valid_i;

   assign s_valid_o  = sel0 | sel1;
   assign s_write_o  = (sel0 & r0_write_i) | (sel1 & r1_write_i);
   assign s_wstrb_o  = ({4{sel0}} & r0_wstrb_i) | ({4{sel1}} & r1_wstrb_i);
   assign s_addr_o   = ({32{sel0}} & r0_addr_i) | ({32{sel1}} & r1_addr_i);
   assign s_wdata_o  = ({32{sel0}} & r0_wdata_i) | ({32{sel1}} & r1_wdata_i);

   assign r0_ready_o = sel0 & s_ready_i;
   assign r1_ready_o = sel1 & s_ready_i;
   assign r0_rdata_o = {32{sel0}} & s_rdata_i;
   assign r1_rdata_o = {32{sel1}} & s_rdata_i;

   assign done       = s_valid_o & s_ready_i;
   assign cur_lock   = (sel0 & r0_lock_i) | (sel1 & r1_lock_i);
   assign owner_o    = {gnt1, gnt0};
   assign lock_err_o = timeout;

   // Arbiter state machine: IDLE picks a requester, BUSY freezes it over a stall, LOCKED keeps it across a 64-bit pair.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         own_r1   <= 1'b0;
         rr_last  <= 1'b1;
         lock_cnt <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt0 || gnt1) begin
                  own_r1 <= gnt1;
                  if (!done) begin
                     state <= ST_BUSY;
                  end else if (cur_lock) begin
                     state    <= ST_LOCKED;
                     lock_cnt <= 8'd0;
                  end else begin
                     rr_last <= gnt1;
                  end
               end
            end
            ST_BUSY: begin
               if (done) begin
                  if (cur_lock) begin
                     state    <= ST_LOCKED;
                     lock_cnt <= 8'd0;
                  end else begin
                     state   <= ST_IDLE;
                     rr_last <= own_r1;
                  end
               end
            end
            ST_LOCKED: begin
               if (timeout) begin
                  state    <= ST_IDLE;
                  rr_last  <= own_r1;
                  lock_cnt <= 8'd0;
               end else if (done) begin
                  lock_cnt <= 8'd0;
                  if (!cur_lock) begin
                     state   <= ST_IDLE;
                     rr_last <= own_r1;
                  end
               end else if (owner_valid) begin
                  lock_cnt <= 8'd0;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef HACD_REG_ARB_STATS_EN
   // Saturating counts of completed beats per requester and of watchdog releases.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_cnt0_o  <= '0;
         grant_cnt1_o  <= '0;
         timeout_cnt_o <= 8'd0;
      end else begin
         if (done && sel0 && grant_cnt0_o != {CNT_W{1'b1}}) grant_cnt0_o <= grant_cnt0_o + 1'b1;
         if (done && sel1 && grant_cnt1_o != {CNT_W{1'b1}}) grant_cnt1_o <= grant_cnt1_o + 1'b1;
         if (timeout && timeout_cnt_o != 8'hFF)             timeout_cnt_o <= timeout_cnt_o + 8'd1;
      end
   end
`endif

endmodule
